// File: rtl/global_types.sv
// Shared types and constants for the UART transmitter peripheral.
// Holds the FSM state enum, register offsets and reset divisor.
package global_types;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_state_t;

  localparam logic [1:0] UART_DATA   = 2'd0;
  localparam logic [1:0] UART_STATUS = 2'd1;
  localparam logic [1:0] UART_DIV    = 2'd2;
  localparam logic [1:0] UART_CTRL   = 2'd3;

  // 433 gives 115200 baud from a 50 MHz clock
  localparam int UART_DIV_RESET = 433;

  function automatic logic [31:0] pack_status(
    input logic       busy,
    input logic       full,
    input logic       empty,
    input logic       ovf,
    input logic [3:0] cnt
  );
    pack_status = {24'd0, cnt, ovf, empty, full, busy};
  endfunction

endpackage

// File: rtl/fifo_sync.sv
// Synchronous FIFO with flush; ports push/pop/flush, din/dout,
// full/empty/count. Flush beats push; push on full needs a pop.
module fifo_sync #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty && !flush;
  assign do_push = push && !flush && (!full || do_pop);
  assign dout    = mem[rptr];

  always_ff @(posedge clock) begin
    if (do_push) mem[wptr] <= din;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_periph.sv
// Memory-mapped 8N1 UART transmitter: DATA/STATUS/DIV/CTRL regs,
// byte FIFO, baud FSM. Bus: we/addr/wd/rd; serial: tx, tx_busy.
module uart_tx_periph
  import global_types::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int DIV_WIDTH  = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        we,
  input  logic [1:0]  addr,
  input  logic [31:0] wd,
  output logic [31:0] rd,
  output logic        tx,
  output logic        tx_busy
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic                 wr_data;
  logic                 wr_status;
  logic                 wr_div;
  logic                 wr_ctrl;
  logic                 flush;
  logic                 enable;
  logic                 ovf;
  logic [DIV_WIDTH-1:0] div_q;

  logic                 f_full;
  logic                 f_empty;
  logic [CW-1:0]        f_count;
  logic [7:0]           f_dout;
  logic                 start_ok;
  logic                 pop;

  uart_state_t          state;
  logic [DIV_WIDTH-1:0] cnt;
  logic [DIV_WIDTH-1:0] frame_div;
  logic [7:0]           shreg;
  logic [2:0]           idx;
  logic                 unused_wd;

  assign unused_wd = ^wd[31:DIV_WIDTH];

  assign wr_data   = we && (addr == UART_DATA);
  assign wr_status = we && (addr == UART_STATUS);
  assign wr_div    = we && (addr == UART_DIV);
  assign wr_ctrl   = we && (addr == UART_CTRL);
  assign flush     = wr_ctrl && wd[1];

  // a flush cycle never starts a frame, so the FIFO head is stable
  assign start_ok = enable && !f_empty && !flush;
  assign pop      = start_ok &&
                    ((state == IDLE) ||
                     ((state == STOP) && (cnt == '0)));

  assign tx_busy  = (state != IDLE);

  fifo_sync #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (wr_data),
    .pop   (pop),
    .flush (flush),
    .din   (wd[7:0]),
    .dout  (f_dout),
    .full  (f_full),
    .empty (f_empty),
    .count (f_count)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      enable <= 1'b0;
      ovf    <= 1'b0;
      div_q  <= DIV_WIDTH'(UART_DIV_RESET);
    end else begin
      if (wr_ctrl) enable <= wd[0];
      if (wr_div)  div_q  <= wd[DIV_WIDTH-1:0];
      if (wr_status) begin
        ovf <= 1'b0;
      end else if (wr_data && f_full && !pop && !flush) begin
        ovf <= 1'b1;
      end
    end
  end

  // frame_div freezes the bit period so DIV writes hit the next frame
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      frame_div <= '0;
      shreg     <= '0;
      idx       <= '0;
      tx        <= 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          tx <= 1'b1;
          if (pop) begin
            state     <= START;
            cnt       <= div_q;
            frame_div <= div_q;
            shreg     <= f_dout;
            tx        <= 1'b0;
          end
        end
        START: begin
          if (cnt == '0) begin
            state <= DATA;
            cnt   <= frame_div;
            idx   <= '0;
            tx    <= shreg[0];
          end else begin
            cnt <= cnt - DIV_WIDTH'(1);
          end
        end
        DATA: begin
          if (cnt == '0) begin
            cnt <= frame_div;
            idx <= idx + 3'd1;
            if (idx == 3'd7) begin
              state <= STOP;
              tx    <= 1'b1;
            end else begin
              shreg <= {1'b0, shreg[7:1]};
              tx    <= shreg[1];
            end
          end else begin
            cnt <= cnt - DIV_WIDTH'(1);
          end
        end
        STOP: begin
          if (cnt == '0) begin
            if (pop) begin
              state     <= START;
              cnt       <= div_q;
              frame_div <= div_q;
              shreg     <= f_dout;
              tx        <= 1'b0;
            end else begin
              state <= IDLE;
            end
          end else begin
            cnt <= cnt - DIV_WIDTH'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    rd = '0;
    unique case (1'b1)
      addr == UART_STATUS:
        rd = pack_status(tx_busy, f_full, f_empty, ovf,
                         4'(f_count));
      addr == UART_DIV:  rd = 32'(div_q);
      addr == UART_CTRL: rd = {31'd0, enable};
      default:           rd = '0;
    endcase
  end

endmodule
